// File: rtl/alu_result_queue.sv
// First-word-fall-through queue of ALU results tagged with their opcode and
// status flags, plus a saturating counter of accepted carry-out events.
module alu_result_queue #(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    y_in,
  input  logic          cout_in,
  input  logic [2:0]    op_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    y_out,
  output logic [2:0]    op_out,
  output logic [3:0]    flags_out,
  output logic [CW-1:0] count,
  input  logic          clr_stats,
  output logic [7:0]    carry_cnt
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [7:0]    yMem_q     [DEPTH];
  logic [2:0]    opMem_q    [DEPTH];
  logic [3:0]    flagsMem_q [DEPTH];

  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    carry_q, carry_d;

  logic          enq;
  logic          deq;
  logic [3:0]    flagsIn;

  // Ready/valid come only from the registered count, so a full queue never
  // accepts even when the head is being drained in the same cycle.
  assign in_ready  = (count_q < FULL);
  assign out_valid = (count_q != '0);
  assign enq       = in_valid && in_ready;
  assign deq       = out_valid && out_ready;

  assign flagsIn = {(y_in == 8'h00), y_in[7], cout_in, ^y_in};

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    carry_d = carry_q;

    if (enq) begin
      wrPtr_d = wrPtr_q + PW'(1);
    end
    if (deq) begin
      rdPtr_d = rdPtr_q + PW'(1);
    end

    if (enq && !deq) begin
      count_d = count_q + CW'(1);
    end else if (!enq && deq) begin
      count_d = count_q - CW'(1);
    end

    if (clr_stats) begin
      carry_d = 8'h00;
    end else if (enq && cout_in && (carry_q != 8'hFF)) begin
      carry_d = carry_q + 8'h01;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      carry_q <= 8'h00;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
      carry_q <= carry_d;
    end
  end

  // Payload storage is deliberately left unreset; it is only meaningful under out_valid.
  always_ff @(posedge clk) begin
    if (enq && rst_n) begin
      yMem_q[wrPtr_q]     <= y_in;
      opMem_q[wrPtr_q]    <= op_in;
      flagsMem_q[wrPtr_q] <= flagsIn;
    end
  end

  assign y_out     = yMem_q[rdPtr_q];
  assign op_out    = opMem_q[rdPtr_q];
  assign flags_out = flagsMem_q[rdPtr_q];
  assign count     = count_q;
  assign carry_cnt = carry_q;

endmodule

// File: tb/tb_alu_result_queue.sv
// Randomised and directed checks of alu_result_queue against a queue-based
// reference model of accepted ALU results.
module tb_alu_result_queue;

  localparam int DEPTH = 4;
  localparam int CW    = 3;

  typedef struct {
    logic [7:0] y;
    logic [2:0] op;
    logic [3:0] flags;
  } entry_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    y_in;
  logic          cout_in;
  logic [2:0]    op_in;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    y_out;
  logic [2:0]    op_out;
  logic [3:0]    flags_out;
  logic [CW-1:0] count;
  logic          clr_stats;
  logic [7:0]    carry_cnt;

  entry_t modelQ[$];
  int     modelCarry;
  int     compared   = 0;
  int     mismatched = 0;

  alu_result_queue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .y_in(y_in), .cout_in(cout_in), .op_in(op_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .y_out(y_out), .op_out(op_out), .flags_out(flags_out),
    .count(count), .clr_stats(clr_stats), .carry_cnt(carry_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic entry_t makeEntry(input logic [7:0] y, input logic c, input logic [2:0] op);
    entry_t e;
    int ones;
    ones = 0;
    for (int b = 0; b < 8; b++) ones += (y >> b) & 1;
    e.y     = y;
    e.op    = op;
    e.flags = {(y == 0) ? 1'b1 : 1'b0, (y >= 128) ? 1'b1 : 1'b0, c, (ones % 2 == 1) ? 1'b1 : 1'b0};
    return e;
  endfunction

  // Called at a negative edge; compares everything visible against the model.
  task automatic checkAll(input string phase);
    checkOutput({phase, ".count"}, count, modelQ.size());
    checkOutput({phase, ".in_ready"}, in_ready, (modelQ.size() < DEPTH) ? 1 : 0);
    checkOutput({phase, ".out_valid"}, out_valid, (modelQ.size() != 0) ? 1 : 0);
    checkOutput({phase, ".carry_cnt"}, carry_cnt, modelCarry);
    if (modelQ.size() != 0) begin
      checkOutput({phase, ".y_out"}, y_out, modelQ[0].y);
      checkOutput({phase, ".op_out"}, op_out, modelQ[0].op);
      checkOutput({phase, ".flags_out"}, flags_out, modelQ[0].flags);
    end
  endtask

  // Drives one cycle from a negative edge, lets the DUT clock it, updates the
  // model with the same acceptance rules and returns at the next negative edge.
  task automatic applyStimulus(input logic v, input logic [7:0] y, input logic c,
                               input logic [2:0] op, input logic rdy, input logic clr);
    bit acc, dq;
    in_valid  = v;
    y_in      = y;
    cout_in   = c;
    op_in     = op;
    out_ready = rdy;
    clr_stats = clr;
    acc = v && (modelQ.size() < DEPTH);
    dq  = rdy && (modelQ.size() != 0);
    @(posedge clk);
    if (dq) void'(modelQ.pop_front());
    if (acc) modelQ.push_back(makeEntry(y, c, op));
    if (clr) modelCarry = 0;
    else if (acc && c && modelCarry < 255) modelCarry++;
    @(negedge clk);
  endtask

  task automatic idleDrain(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0);
  endtask

  initial begin
    logic [3:0] expFlags [4];
    logic [7:0] fillVals [4];
    int pRdy;
    expFlags[0] = 4'b0101; expFlags[1] = 4'b0001; expFlags[2] = 4'b0001; expFlags[3] = 4'b0100;
    fillVals[0] = 8'h80;   fillVals[1] = 8'h7F;   fillVals[2] = 8'h01;   fillVals[3] = 8'hFF;

    rst_n = 1'b0; in_valid = 1'b0; y_in = 8'h00; cout_in = 1'b0; op_in = 3'd0;
    out_ready = 1'b0; clr_stats = 1'b0; modelCarry = 0;
    repeat (3) @(negedge clk);
    checkAll("reset");
    rst_n = 1'b1;

    $display("[TB] first entry latency and flags");
    applyStimulus(1'b1, 8'h00, 1'b1, 3'd2, 1'b0, 1'b0);
    checkAll("first");
    checkOutput("first.flags_const", flags_out, 4'b1010);
    checkOutput("first.carry_const", carry_cnt, 1);
    idleDrain(1);
    checkAll("first_drained");

    $display("[TB] fill to full, reject fifth, drain");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, fillVals[i], 1'b0, 3'(i), 1'b0, 1'b0);
      checkAll("fill");
    end
    checkOutput("full.in_ready", in_ready, 0);
    applyStimulus(1'b1, 8'h55, 1'b0, 3'd7, 1'b0, 1'b0);
    checkAll("fifth_rejected");
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain.flags_const", flags_out, expFlags[i]);
      applyStimulus(1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0);
      checkAll("drain");
    end
    checkOutput("drain.count_zero", count, 0);

    $display("[TB] full with simultaneous valid and ready");
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'(8'hA0 + i), 1'(i), 3'(i), 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b1, 3'd5, 1'b1, 1'b0);
    checkAll("full_both");
    checkOutput("full_both.count_const", count, 3);

    $display("[TB] steady stream across pointer wrap");
    idleDrain(2);
    checkOutput("stream.start_count", count, 1);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 8'(8'h10 + i), 1'b0, 3'(i), 1'b1, 1'b0);
      checkAll("stream");
    end

    $display("[TB] carry counter saturation and clear");
    idleDrain(2);
    applyStimulus(1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1);
    checkAll("carry_clr");
    for (int i = 0; i < 300; i++) applyStimulus(1'b1, 8'($urandom), 1'b1, 3'($urandom), 1'b1, 1'b0);
    checkAll("carry_sat");
    checkOutput("carry_sat.const", carry_cnt, 8'hFF);
    applyStimulus(1'b1, 8'h42, 1'b1, 3'd1, 1'b1, 1'b1);
    checkAll("carry_clr_prio");
    checkOutput("carry_clr_prio.const", carry_cnt, 0);

    $display("[TB] randomised traffic");
    for (int blk = 0; blk < 8; blk++) begin
      pRdy = $urandom_range(10, 90);
      for (int i = 0; i < 60; i++) begin
        applyStimulus(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom),
                      3'($urandom), 1'($urandom_range(0, 99) < pRdy),
                      1'($urandom_range(0, 99) < 3));
        checkAll("random");
      end
    end

    $display("[TB] asynchronous reset mid-stream");
    idleDrain(DEPTH + 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'hC0 + i), 1'b1, 3'(i), 1'b0, 1'b0);
    checkOutput("pre_reset.count", count, 3);
    in_valid = 1'b1; out_ready = 1'b1; y_in = 8'h99; cout_in = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    modelQ.delete();
    modelCarry = 0;
    #1;
    checkAll("async_reset");
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checkAll("reset_held");
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom), 3'($urandom),
                    1'($urandom_range(0, 1)), 1'b0);
      checkAll("after_reset");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
